aether_mem_arbiter: RTL

- Round-robin task arbiter sharing one aether generic memory engine (SDRAM or BRAM variant) between NumRequesters clients.
- Each client posts a whole task (command, start address, end address).
- The arbiter issues the task as a single-cycle command pulse, steers write data and read strobes to the owner, and detects completion or timeout.
- Sits between compute engines (weight/activation loaders, result writers) and the memory engine.

---
 rtl/aether_mem_arbiter_if.sv | 40 ++++
 rtl/aether_mem_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/aether_mem_arbiter_if.sv
// aether_mem_arbiter_if: client task requests plus memory-engine command/response bus; slave = arbiter side, master = clients and engine side
interface aether_mem_arbiter_if #(
  parameter int NumRequesters = 2
);
  logic [NumRequesters-1:0]    req_i;
  logic [2*NumRequesters-1:0]  req_cmd_i;
  logic [32*NumRequesters-1:0] req_start_address_i;
  logic [32*NumRequesters-1:0] req_end_address_i;
  logic [16*NumRequesters-1:0] req_data_write_i;
  logic [NumRequesters-1:0]    grant_o;
  logic [15:0]                 req_data_read_o;
  logic [NumRequesters-1:0]    req_data_read_valid_o;
  logic [NumRequesters-1:0]    req_data_write_done_o;
  logic [NumRequesters-1:0]    req_done_o;
  logic                        cmd_error_o;
  logic                        timeout_o;
  logic [1:0]                  mem_command_o;
  logic [31:0]                 mem_start_address_o;
  logic [31:0]                 mem_end_address_o;
  logic [15:0]                 mem_data_write_o;
  logic                        mem_rst_o;
  logic [15:0]                 mem_data_read_i;
  logic                        mem_data_read_valid_i;
  logic                        mem_data_write_done_i;
  logic                        mem_task_finished_i;
  modport slave (
    input  req_i, req_cmd_i, req_start_address_i, req_end_address_i, req_data_write_i,
    input  mem_data_read_i, mem_data_read_valid_i, mem_data_write_done_i, mem_task_finished_i,
    output grant_o, req_data_read_o, req_data_read_valid_o, req_data_write_done_o, req_done_o,
    output cmd_error_o, timeout_o, mem_command_o, mem_start_address_o, mem_end_address_o,
    output mem_data_write_o, mem_rst_o
  );
  modport master (
    output req_i, req_cmd_i, req_start_address_i, req_end_address_i, req_data_write_i,
    output mem_data_read_i, mem_data_read_valid_i, mem_data_write_done_i, mem_task_finished_i,
    input  grant_o, req_data_read_o, req_data_read_valid_o, req_data_write_done_o, req_done_o,
    input  cmd_error_o, timeout_o, mem_command_o, mem_start_address_o, mem_end_address_o,
    input  mem_data_write_o, mem_rst_o
  );
endinterface

// File: rtl/aether_mem_arbiter.sv
// aether_mem_arbiter: round-robin task arbiter for one memory engine; ports clk_i, rst_i (sync active-high) and bus (slave side of aether_mem_arbiter_if)
module aether_mem_arbiter #(
  parameter int          NumRequesters = 2,
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  aether_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(NumRequesters);
  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, BUSY, DONE} state_t;
  state_t                   r_state;
  logic [IW-1:0]            r_owner, r_ptr, w_sel;
  logic [NumRequesters-1:0] r_grant, r_done, w_sel_oh;
  logic [1:0]               r_mem_cmd;
  logic                     r_bad, r_cmd_err, r_timeout, r_abort, w_expire;
  logic [31:0]              r_start, r_end, r_cnt;
  logic [1:0]               w_cmd   [NumRequesters];
  logic [31:0]              w_start [NumRequesters];
  logic [31:0]              w_end   [NumRequesters];
  logic [15:0]              w_wdata [NumRequesters];
  for (genvar g = 0; g < NumRequesters; g++) begin : g_unpack
    assign w_cmd[g]   = bus.req_cmd_i[2*g +: 2];
    assign w_start[g] = bus.req_start_address_i[32*g +: 32];
    assign w_end[g]   = bus.req_end_address_i[32*g +: 32];
    assign w_wdata[g] = bus.req_data_write_i[16*g +: 16];
  end
  always_comb begin
    w_sel = r_ptr;
    for (int i = NumRequesters; i >= 1; i--)
      if (bus.req_i[IW'((int'(r_ptr) + i) % NumRequesters)]) w_sel = IW'((int'(r_ptr) + i) % NumRequesters);
  end
  assign w_sel_oh = NumRequesters'(1) << w_sel;
  assign w_expire = (TimeoutCycles != 0) && (r_cnt == 32'(TimeoutCycles - 1));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_ptr     <= IW'(NumRequesters - 1);
      r_grant   <= '0;
      r_done    <= '0;
      r_mem_cmd <= '0;
      r_bad     <= 1'b0;
      r_cmd_err <= 1'b0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
      r_start   <= '0;
      r_end     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: if (|bus.req_i) begin
          r_state   <= ISSUE;
          r_owner   <= w_sel;
          r_ptr     <= w_sel;
          r_grant   <= w_sel_oh;
          r_bad     <= ~^w_cmd[w_sel];
          r_mem_cmd <= ^w_cmd[w_sel] ? w_cmd[w_sel] : 2'b00;
          r_start   <= w_start[w_sel];
          r_end     <= w_end[w_sel];
        end
        ISSUE: begin
          r_mem_cmd <= 2'b00;
          r_state   <= r_bad ? DONE : GUARD;
          r_done    <= r_bad ? r_grant : '0;
          r_cmd_err <= r_cmd_err | r_bad;
        end
        GUARD: begin
          r_state <= BUSY;
          r_cnt   <= '0;
        end
        BUSY: if (bus.mem_task_finished_i || w_expire) begin
          r_state   <= DONE;
          r_done    <= r_grant;
          r_timeout <= r_timeout | ~bus.mem_task_finished_i;
          r_abort   <= ~bus.mem_task_finished_i;
        end else r_cnt <= r_cnt + 32'd1;
        DONE: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_done  <= '0;
          r_abort <= 1'b0;
          r_start <= '0;
          r_end   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.grant_o               = r_grant;
  assign bus.req_data_read_o       = bus.mem_data_read_i;
  assign bus.req_data_read_valid_o = r_grant & {NumRequesters{bus.mem_data_read_valid_i}};
  assign bus.req_data_write_done_o = r_grant & {NumRequesters{bus.mem_data_write_done_i}};
  assign bus.req_done_o            = r_done;
  assign bus.cmd_error_o           = r_cmd_err;
  assign bus.timeout_o             = r_timeout;
  assign bus.mem_command_o         = r_mem_cmd;
  assign bus.mem_start_address_o   = r_start;
  assign bus.mem_end_address_o     = r_end;
  assign bus.mem_data_write_o      = |r_grant ? w_wdata[r_owner] : 16'h0000;
  assign bus.mem_rst_o             = rst_i | r_abort;
endmodule
